// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared constants, FSM states and per-channel recovery math for scene_recovery_sr
//
// Purpose : constants for the scene-radiance recovery stage, the FSM state
//           enum, and the per-channel J = A + (I - A) * recip clamp function.
// Ports   : none (package).
// Config  : SR_RECIP_CACHE_EN is consumed by scene_recovery_sr, not here.

package sr_pkg;

  localparam int PIX_W      = 8;
  localparam int T_W        = 14;
  localparam int RECIP_W    = 14;
  localparam int RECIP_FRAC = 12;
  localparam int DIV_STEPS  = 14;
  localparam int CNT_W      = $clog2(DIV_STEPS);

  localparam logic [T_W-1:0] T0  = 14'd5734;
  localparam logic [T_W-1:0] ONE = 14'd16383;

  localparam logic [26:0] DIVIDEND = 27'd1 << 26;

  // t_c >= T0 > 2^12, so the upper 13 quotient bits of 2^26 / t_c are always
  // zero. The divider starts with those dividend bits already folded into the
  // remainder and only iterates over the low DIV_STEPS bits.
  localparam logic [T_W-1:0] DIV_REM_INIT = T_W'(DIVIDEND >> DIV_STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    OUT  = 2'd3
  } sr_state_e;

  // out = clamp(A + floor((I - A) * recip / 2^RECIP_FRAC), 0, 255)
  function automatic logic [PIX_W-1:0] recover_chan(
    input logic [PIX_W-1:0]   i,
    input logic [PIX_W-1:0]   a,
    input logic [RECIP_W-1:0] recip
  );
    logic signed [8:0]  d;
    logic signed [23:0] p;
    logic signed [23:0] q;
    logic signed [10:0] s;
    logic [PIX_W-1:0]   r;
    d = $signed({1'b0, i}) - $signed({1'b0, a});
    p = 24'(d) * 24'($signed({1'b0, recip}));
    q = p >>> RECIP_FRAC;
    // |q| <= 255 * 11703 / 4096 < 729, so 11 signed bits hold it exactly
    s = $signed({3'b000, a}) + $signed(q[10:0]);
    if (s < 11'sd0) begin
      r = '0;
    end else if (s > 11'sd255) begin
      r = 8'hFF;
    end else begin
      r = s[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sr_recip_div.sv
// rtl/sr_recip_div.sv - iterative restoring divider producing floor(2^26 / divisor)
//
// Purpose : one quotient bit per cycle, DIV_STEPS cycles after start.
// Ports   : clk, rst       clock, asynchronous active-high reset
//           start_i        load divisor_i and begin (ignored while busy)
//           divisor_i      14-bit divisor, must be >= T0
//           busy_o         iteration in progress
//           done_o         final quotient bit is computed this cycle; quot_o
//                          is complete from the next cycle on
//           quot_o         14-bit quotient (unsigned Q2.12 reciprocal)

module sr_recip_div
  import sr_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [T_W-1:0]     divisor_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [RECIP_W-1:0] quot_o
);

  logic [T_W-1:0]     divisor_q, divisor_d;
  logic [T_W-1:0]     rem_q, rem_d;
  logic [RECIP_W-1:0] quot_q, quot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [T_W:0]       trial;
  logic [T_W:0]       trial_sub;
  logic               ge;
  logic               last_step;

  // Remainder stays below divisor (< 2^14), so the shifted trial fits in 15 bits.
  assign trial     = {rem_q, 1'b0};
  assign ge        = trial >= {1'b0, divisor_q};
  assign trial_sub = trial - {1'b0, divisor_q};
  assign last_step = busy_q && (cnt_q == CNT_W'(DIV_STEPS - 1));

  always_comb begin
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (start_i && !busy_q) begin
      divisor_d = divisor_i;
      rem_d     = DIV_REM_INIT;
      quot_d    = '0;
      cnt_d     = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      rem_d  = ge ? trial_sub[T_W-1:0] : trial[T_W-1:0];
      quot_d = {quot_q[RECIP_W-2:0], ge};
      cnt_d  = cnt_q + 1'b1;
      if (last_step) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last_step;
  assign quot_o = quot_q;

endmodule

// File: rtl/scene_recovery_sr.sv
// rtl/scene_recovery_sr.sv - scene radiance recovery J = A + (I - A) / t, last dehaze stage
//
// Purpose : accepts a hazy pixel, its atmospheric light and a Q0.14
//           transmission, computes 1/t with an iterative divider, then one
//           multiply/clamp cycle, and presents the recovered pixel.
// Ports   : clk, rst                 clock, asynchronous active-high reset
//           in_valid / in_ready      input handshake
//           pix_r/g/b, atm_r/g/b     I and A, 8 bits per channel
//           t_in                     transmission Q0.14, clamped up to T0
//           out_valid / out_ready    output handshake
//           out_r/g/b                recovered pixel, held while out_valid
// Config  : SR_RECIP_CACHE_EN - reuse the last reciprocal when t repeats,
//           skipping the divider (2-edge latency instead of 15).

module scene_recovery_sr
  import sr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] pix_r,
  input  logic [PIX_W-1:0] pix_g,
  input  logic [PIX_W-1:0] pix_b,
  input  logic [PIX_W-1:0] atm_r,
  input  logic [PIX_W-1:0] atm_g,
  input  logic [PIX_W-1:0] atm_b,
  input  logic [T_W-1:0]   t_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_r,
  output logic [PIX_W-1:0] out_g,
  output logic [PIX_W-1:0] out_b
);

  sr_state_e state_q, state_d;

  logic [2:0][PIX_W-1:0] i_q;
  logic [2:0][PIX_W-1:0] a_q;
  logic [2:0][PIX_W-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;

  logic [T_W-1:0]     t_c;
  logic               accept;
  logic               cache_hit;
  logic               mul_fire;
  logic               div_start;
  logic               div_busy;
  logic               div_done;
  logic [RECIP_W-1:0] div_quot;
  logic [RECIP_W-1:0] recip_mul;

  assign t_c      = (t_in < T0) ? T0 : t_in;
  // Both terms are registered, so in_valid never reaches in_ready.
  assign in_ready = (state_q == IDLE) && !div_busy;
  assign accept   = in_valid && in_ready;

`ifdef SR_RECIP_CACHE_EN
  logic [T_W-1:0]     t_q;
  logic [T_W-1:0]     last_t_q;
  logic [RECIP_W-1:0] last_recip_q;
  logic [RECIP_W-1:0] recip_q;
  logic               cache_valid_q;
  logic               hit_q;
  logic               load_q;

  assign cache_hit = cache_valid_q && (t_c == last_t_q);
  // On a hit the first MUL cycle only registers the cached reciprocal; the
  // multiply happens on the second, giving the 2-edge hit latency.
  assign mul_fire  = (state_q == MUL) && !load_q;
  assign recip_mul = hit_q ? recip_q : div_quot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q           <= '0;
      last_t_q      <= '0;
      last_recip_q  <= '0;
      recip_q       <= '0;
      cache_valid_q <= 1'b0;
      hit_q         <= 1'b0;
      load_q        <= 1'b0;
    end else begin
      if (accept) begin
        t_q    <= t_c;
        hit_q  <= cache_hit;
        load_q <= cache_hit;
      end
      if ((state_q == MUL) && load_q) begin
        recip_q <= last_recip_q;
        load_q  <= 1'b0;
      end
      if (mul_fire && !hit_q) begin
        last_t_q      <= t_q;
        last_recip_q  <= div_quot;
        cache_valid_q <= 1'b1;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign mul_fire  = (state_q == MUL);
  assign recip_mul = div_quot;
`endif

  assign div_start = accept && !cache_hit;

  sr_recip_div u_recip_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .divisor_i (t_c),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quot_o    (div_quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      a_q <= '0;
    end else if (accept) begin
      i_q <= {pix_b, pix_g, pix_r};
      a_q <= {atm_b, atm_g, atm_r};
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = cache_hit ? MUL : DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = MUL;
        end
      end
      MUL: begin
        if (mul_fire) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          for (int c = 0; c < 3; c++) begin
            out_d[c] = recover_chan(i_q[c], a_q[c], recip_mul);
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_q[0];
  assign out_g     = out_q[1];
  assign out_b     = out_q[2];

endmodule

// File: tb/tb_scene_recovery_sr.sv
// tb/tb_scene_recovery_sr.sv - scoreboard bench for scene_recovery_sr (honours SR_RECIP_CACHE_EN)

module tb_scene_recovery_sr;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [7:0]  atm_r, atm_g, atm_b;
  logic [13:0] t_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_r, out_g, out_b;

  scene_recovery_sr dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pix_r     (pix_r),
    .pix_g     (pix_g),
    .pix_b     (pix_b),
    .atm_r     (atm_r),
    .atm_g     (atm_g),
    .atm_b     (atm_b),
    .t_in      (t_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_g     (out_g),
    .out_b     (out_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int r;
    int g;
    int b;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];

  bit cm_valid = 1'b0;
  int cm_t     = 0;
  bit prev_ov  = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_chan(input int i, input int a, input int t);
    int tc, rc, p, s;
    tc = (t < 5734) ? 5734 : t;
    rc = (1 << 26) / tc;
    p  = (i - a) * rc;
    s  = a + (p >>> 12);
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic drive(input int t, input int ir, input int ig, input int ib,
                       input int ar, input int ag, input int ab, input bit push,
                       input int er, input int eg, input int eb);
    int   k;
    int   tc;
    exp_t e;
    @(negedge clk);
    t_in  = 14'(t);
    pix_r = 8'(ir); pix_g = 8'(ig); pix_b = 8'(ib);
    atm_r = 8'(ar); atm_g = 8'(ag); atm_b = 8'(ab);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      tc = (t < 5734) ? 5734 : t;
`ifdef SR_RECIP_CACHE_EN
      e.lat = (cm_valid && cm_t == tc) ? 2 : 15;
`else
      e.lat = 15;
`endif
      cm_valid = 1'b1;
      cm_t     = tc;
      e.r = er; e.g = eg; e.b = eb;
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drive_rand();
    int t, ir, ig, ib, ar, ag, ab;
    t  = $urandom_range(0, 16383);
    ir = $urandom_range(0, 255); ig = $urandom_range(0, 255); ib = $urandom_range(0, 255);
    ar = $urandom_range(0, 255); ag = $urandom_range(0, 255); ab = $urandom_range(0, 255);
    drive(t, ir, ig, ib, ar, ag, ab, 1'b1,
          model_chan(ir, ar, t), model_chan(ig, ag, t), model_chan(ib, ab, t));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_r", int'(out_r), e.r);
        check("out_g", int'(out_g), e.g);
        check("out_b", int'(out_b), e.b);
        check("latency", cyc - e.acc, e.lat);
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    pix_r = '0; pix_g = '0; pix_b = '0;
    atm_r = '0; atm_g = '0; atm_b = '0; t_in = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_r", int'(out_r), 0);
    check("rst_out_g", int'(out_g), 0);
    check("rst_out_b", int'(out_b), 0);
    rst = 1'b0;
    out_ready = 1'b1;

    drive(16383, 200, 100, 50, 220, 220, 220, 1'b1, 200, 100, 50);
    drain();
    drive(5734, 255, 0, 210, 200, 200, 200, 1'b1, 255, 0, 228);
    drain();
    drive(1000, 255, 0, 210, 200, 200, 200, 1'b1, 255, 0, 228);
    drain();
    drive(0, 255, 0, 210, 200, 200, 200, 1'b1, 255, 0, 228);
    drain();

    // downstream stall: result held, no new accept until the handshake
    out_ready = 1'b0;
    drive(8192, 100, 100, 100, 150, 150, 150, 1'b1, 50, 50, 50);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("hold_seen", int'(out_valid), 1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("hold_r", int'(out_r), 50);
      check("hold_g", int'(out_g), 50);
      check("hold_b", int'(out_b), 50);
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_in_ready", int'(in_ready), 1);
    check("post_hs_valid", int'(out_valid), 0);
    drain();

    // reset in DIV cycle 7 aborts the pixel
    drive(16383, 10, 20, 30, 40, 50, 60, 1'b0, 0, 0, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cm_valid = 1'b0;
    #1;
    check("abort_valid", int'(out_valid), 0);
    check("abort_out_r", int'(out_r), 0);
    check("abort_out_g", int'(out_g), 0);
    check("abort_out_b", int'(out_b), 0);
    check("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    drive(8192, 100, 100, 100, 150, 150, 150, 1'b1, 50, 50, 50);
    drain();

    // back-to-back identical t: in_valid stays high while busy
    drive(5734, 255, 0, 210, 200, 200, 200, 1'b1, 255, 0, 228);
    drive(5734, 100, 100, 100, 150, 150, 150, 1'b1,
          model_chan(100, 150, 5734), model_chan(100, 150, 5734), model_chan(100, 150, 5734));
    drain();

    for (int n = 0; n < 8; n++) begin
      drive_rand();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
